param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/param_register.sv | 42 ++++
 rtl/param_register_file.sv | 121 ++++++++++++
 tb/tb_param_register_file.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared codes for the register file: FunSel operations, SwapMode transfer kinds
// and the bank-transfer controller state.
package regfile_pkg;

    localparam logic [2:0] FS_DEC  = 3'b000;
    localparam logic [2:0] FS_INC  = 3'b001;
    localparam logic [2:0] FS_LOAD = 3'b010;
    localparam logic [2:0] FS_CLR  = 3'b011;

    localparam logic [1:0] SM_SAVE    = 2'b00;
    localparam logic [1:0] SM_RESTORE = 2'b01;
    localparam logic [1:0] SM_XCHG    = 2'b10;
    localparam logic [1:0] SM_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/param_register.sv
// One WIDTH-bit register cell: applies FunSel when E is high, otherwise holds.
// Synchronous active-low reset clears it.
module param_register
    import regfile_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       FunSel,
    input  logic             E,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q, q_d;

    // Increment/decrement wrap naturally at WIDTH bits; codes 1xx hold.
    always_comb begin
        q_d = q_q;
        if (E) begin
            case (FunSel)
                FS_DEC:  q_d = q_q - WIDTH'(1);
                FS_INC:  q_d = q_q + WIDTH'(1);
                FS_LOAD: q_d = I;
                FS_CLR:  q_d = '0;
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/param_register_file.sv
// General bank R[] and scratch bank S[] with two combinational read ports and a
// sequential bank-transfer engine (save / restore / exchange, one index per cycle).
module param_register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 4
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [WIDTH-1:0]            I,
    input  logic [2:0]                  FunSel,
    input  logic [NREG-1:0]             RegSel,
    input  logic [NREG-1:0]             ScrSel,
    input  logic [$clog2(2*NREG)-1:0]   OutASel,
    input  logic [$clog2(2*NREG)-1:0]   OutBSel,
    output logic [WIDTH-1:0]            OutA,
    output logic [WIDTH-1:0]            OutB,
    input  logic                        Swap,
    input  logic [1:0]                  SwapMode,
    output logic                        Busy,
    output logic                        Done,
    output state_e                      dbg_state_o
);

    localparam int NCELL = 2 * NREG;
    localparam int IDXW  = $clog2(NREG);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [1:0]       mode_q, mode_d;
    logic             swap_acc;
    logic             ext_we;
    logic [WIDTH-1:0] q [NCELL];

    // Swap is a one-cycle request taken only while IDLE (Busy=0 means ready);
    // requests while Busy are dropped, and an accepted request wins over writes.
    assign swap_acc = (state_q == IDLE) && Swap && (SwapMode != SM_RSVD);
    assign ext_we   = (state_q == IDLE) && !swap_acc;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (swap_acc) begin
                    state_d = XFER;
                    idx_d   = '0;
                    mode_d  = SwapMode;
                end
            end
            XFER: begin
                if (idx_q == IDXW'(NREG - 1)) begin
                    state_d = FINISH;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mode_q  <= SM_SAVE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    // Cells 0..NREG-1 are R[], NREG..2*NREG-1 are S[]; each cell's partner is the
    // same index in the other bank.
    for (genvar c = 0; c < NCELL; c++) begin : g_cell
        localparam int K     = c % NREG;
        localparam bit IS_S  = (c >= NREG);
        localparam int SRC   = IS_S ? K : K + NREG;

        logic             sel_n;
        logic             hit;
        logic             e;
        logic [2:0]       fs;
        logic [WIDTH-1:0] din;

        assign sel_n = IS_S ? ScrSel[NREG-1-K] : RegSel[NREG-1-K];
        assign hit   = (state_q == XFER) && (idx_q == IDXW'(K)) &&
                       (IS_S ? (mode_q != SM_RESTORE) : (mode_q != SM_SAVE));
        assign e     = hit || (ext_we && !sel_n);
        assign fs    = hit ? FS_LOAD : FunSel;
        assign din   = hit ? q[SRC] : I;

        param_register #(.WIDTH(WIDTH)) u_reg (
            .Clock  (Clock),
            .Reset  (Reset),
            .I      (din),
            .FunSel (fs),
            .E      (e),
            .Q      (q[c])
        );
    end

    always_comb begin
        OutA = '0;
        OutB = '0;
        if (Reset) begin
            if (int'(OutASel) < NCELL) OutA = q[OutASel];
            if (int'(OutBSel) < NCELL) OutB = q[OutBSel];
        end
    end

    assign Busy        = Reset && (state_q != IDLE);
    assign Done        = Reset && (state_q == FINISH);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_param_register_file.sv
// Directed and randomized bench for param_register_file against an array-based
// model of the two banks and the transfer timeline.
module tb_param_register_file;
  import regfile_pkg::*;

  localparam int WIDTH = 16;
  localparam int NREG  = 4;
  localparam int SELW  = $clog2(2 * NREG);

  logic             Clock = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] I;
  logic [2:0]       FunSel;
  logic [NREG-1:0]  RegSel;
  logic [NREG-1:0]  ScrSel;
  logic [SELW-1:0]  OutASel;
  logic [SELW-1:0]  OutBSel;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic             Swap;
  logic [1:0]       SwapMode;
  logic             Busy;
  logic             Done;
  state_e           dbg_state;

  int checks   = 0;
  int failures = 0;

  // Model: bank contents plus position in the transfer timeline
  // (-1 idle, 0..NREG-1 about to move that index, NREG = completion cycle).
  logic [WIDTH-1:0] r_m [NREG];
  logic [WIDTH-1:0] s_m [NREG];
  int               pos_m = -1;
  logic [1:0]       mode_m = 2'b00;
  int               done_seen;

  param_register_file #(.WIDTH(WIDTH), .NREG(NREG)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .I           (I),
    .FunSel      (FunSel),
    .RegSel      (RegSel),
    .ScrSel      (ScrSel),
    .OutASel     (OutASel),
    .OutBSel     (OutBSel),
    .OutA        (OutA),
    .OutB        (OutB),
    .Swap        (Swap),
    .SwapMode    (SwapMode),
    .Busy        (Busy),
    .Done        (Done),
    .dbg_state_o (dbg_state)
  );

  always #10 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] apply_fs(input logic [2:0] f, input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] d);
    case (f)
      3'b000:  return v - 1;
      3'b001:  return v + 1;
      3'b010:  return d;
      3'b011:  return '0;
      default: return v;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] model_rd(input int sel);
    return (sel < NREG) ? r_m[sel] : s_m[sel - NREG];
  endfunction

  task automatic model_edge();
    logic [WIDTH-1:0] t;
    if (!Reset) begin
      for (int k = 0; k < NREG; k++) begin
        r_m[k] = '0;
        s_m[k] = '0;
      end
      pos_m = -1;
    end else if (pos_m == NREG) begin
      pos_m = -1;
    end else if (pos_m >= 0) begin
      t = r_m[pos_m];
      if (mode_m == 2'b00) s_m[pos_m] = t;
      if (mode_m == 2'b01) r_m[pos_m] = s_m[pos_m];
      if (mode_m == 2'b10) begin
        r_m[pos_m] = s_m[pos_m];
        s_m[pos_m] = t;
      end
      pos_m++;
    end else if (Swap && SwapMode != 2'b11) begin
      mode_m = SwapMode;
      pos_m  = 0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (!RegSel[NREG-1-k]) r_m[k] = apply_fs(FunSel, r_m[k], I);
        if (!ScrSel[NREG-1-k]) s_m[k] = apply_fs(FunSel, s_m[k], I);
      end
    end
  endtask

  // One clock edge: advance the model, then compare handshake outputs and two
  // random read ports against it.
  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
    OutASel = SELW'($urandom_range(0, 2 * NREG - 1));
    OutBSel = SELW'($urandom_range(0, 2 * NREG - 1));
    #1;
    if (Done) done_seen++;
    check("busy", Busy, (pos_m >= 0) ? 1 : 0);
    check("done", Done, (pos_m == NREG) ? 1 : 0);
    check("outa", OutA, model_rd(int'(OutASel)));
    check("outb", OutB, model_rd(int'(OutBSel)));
  endtask

  task automatic quiet();
    RegSel = '1; ScrSel = '1; FunSel = 3'b100; I = '0; Swap = 1'b0; SwapMode = 2'b00;
  endtask

  task automatic write_reg(input bit scr, input int k, input logic [2:0] f, input logic [WIDTH-1:0] v);
    quiet();
    if (scr) ScrSel[NREG-1-k] = 1'b0;
    else     RegSel[NREG-1-k] = 1'b0;
    FunSel = f;
    I      = v;
    tick();
    quiet();
  endtask

  task automatic read_const(input string tag, input int sel, input logic [WIDTH-1:0] exp);
    OutASel = SELW'(sel);
    OutBSel = SELW'(sel);
    #1;
    check(tag, OutA, exp);
    check({tag, "_b"}, OutB, exp);
  endtask

  task automatic read_all_model();
    for (int s = 0; s < 2 * NREG; s++) begin
      OutASel = SELW'(s);
      #1;
      check("read_all", OutA, model_rd(s));
    end
  endtask

  initial begin
    quiet();
    OutASel = '0;
    OutBSel = '0;
    Reset   = 1'b0;
    #1;
    check("rst_outa_comb", OutA, 0);
    check("rst_busy_comb", Busy, 0);
    check("rst_done_comb", Done, 0);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    read_all_model();

    // Load R[0] via RegSel=0111; every other register stays 0.
    write_reg(0, 0, FS_LOAD, 16'h1234);
    read_const("load_r0", 0, 16'h1234);
    for (int s = 1; s < 2 * NREG; s++) read_const("others_zero", s, 16'h0000);

    // Wrap-around on R[1], R[0] untouched.
    write_reg(0, 1, FS_LOAD, 16'hFFFF);
    write_reg(0, 1, FS_INC, 16'h0000);
    read_const("inc_wrap", 1, 16'h0000);
    write_reg(0, 1, FS_DEC, 16'h0000);
    read_const("dec_wrap", 1, 16'hFFFF);
    read_const("r0_held", 0, 16'h1234);

    // Save: R=1..4, S=0.
    for (int k = 0; k < NREG; k++) write_reg(0, k, FS_LOAD, WIDTH'(k + 1));
    quiet(); ScrSel = '0; FunSel = FS_CLR; tick(); quiet();
    Swap = 1'b1; SwapMode = SM_SAVE; tick(); quiet();
    for (int n = 1; n <= NREG + 1; n++) begin
      check("save_busy", Busy, 1);
      check("save_done", Done, (n == NREG + 1) ? 1 : 0);
      if (n <= NREG) tick();
    end
    tick();
    check("save_busy_end", Busy, 0);
    for (int k = 0; k < NREG; k++) begin
      read_const("save_s", NREG + k, WIDTH'(k + 1));
      read_const("save_r", k, WIDTH'(k + 1));
    end

    // Exchange with S=A..D; mid-transfer Swap, writes and SwapMode are ignored.
    for (int k = 0; k < NREG; k++) write_reg(1, k, FS_LOAD, WIDTH'(16'hA + k));
    Swap = 1'b1; SwapMode = SM_XCHG; tick(); quiet();
    tick();
    Swap = 1'b1; SwapMode = SM_RESTORE; RegSel = '0; ScrSel = '0; FunSel = FS_CLR;
    tick();
    quiet();
    for (int n = 0; n < 2 * NREG; n++) tick();
    for (int k = 0; k < NREG; k++) begin
      read_const("xchg_r", k, WIDTH'(16'hA + k));
      read_const("xchg_s", NREG + k, WIDTH'(k + 1));
    end

    // Reserved SwapMode is not accepted.
    Swap = 1'b1; SwapMode = SM_RSVD; tick(); quiet();
    check("rsvd_ignored", Busy, 0);

    // Reset two cycles into a save aborts without Done.
    done_seen = 0;
    Swap = 1'b1; SwapMode = SM_SAVE; tick(); quiet();
    tick();
    Reset = 1'b0;
    #1;
    check("abort_busy_comb", Busy, 0);
    check("abort_outa_comb", OutA, 0);
    tick();
    Reset = 1'b1;
    for (int n = 0; n < NREG + 2; n++) tick();
    check("abort_no_done", done_seen, 0);
    read_all_model();
    for (int s = 0; s < 2 * NREG; s++) read_const("abort_zero", s, 16'h0000);

    // Swap accepted together with a write: the write is dropped.
    quiet();
    Swap = 1'b1; SwapMode = SM_SAVE; RegSel = 4'b0111; FunSel = FS_LOAD; I = 16'h0055;
    tick();
    quiet();
    check("swap_accepted", Busy, 1);
    for (int n = 0; n < NREG + 1; n++) tick();
    read_const("write_dropped", 0, 16'h0000);

    // Randomized traffic, including occasional resets and reserved modes.
    for (int n = 0; n < 400; n++) begin
      Reset    = ($urandom_range(0, 39) != 0);
      I        = WIDTH'($urandom());
      FunSel   = 3'($urandom_range(0, 7));
      RegSel   = NREG'($urandom());
      ScrSel   = NREG'($urandom());
      Swap     = ($urandom_range(0, 7) == 0);
      SwapMode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        FunSel = 3'($urandom_range(0, 1));
        I      = '1;
      end
      tick();
    end
    Reset = 1'b1;
    quiet();
    tick();
    read_all_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
